uart_tx_buffer: RTL and testbench

//   Byte FIFO plus launch FSM between the receive side (uart_rx strobe) and

---
 rtl/uart_tx_buffer_if.sv | 28 ++
 rtl/uart_tx_buffer.sv | 80 ++++++++
 tb/tb_uart_tx_buffer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: byte-queue bus between the uart_rx strobe, the buffer and uart_tx.
//   master drives the write strobe, uart_tx status and overflow clear;
//   slave (the buffer) drives the uart_tx launch, held byte and queue status.
interface uart_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_valid;
    logic [7:0]            wr_data;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  clr_overflow;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic [DEPTH_LOG2:0]   level;
    logic                  empty;
    logic                  full;
    logic                  overflow;

    modport master (
        output wr_valid, wr_data, tx_busy, tx_done, clr_overflow,
        input  tx_start, tx_data, level, empty, full, overflow
    );

    modport slave (
        input  wr_valid, wr_data, tx_busy, tx_done, clr_overflow,
        output tx_start, tx_data, level, empty, full, overflow
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus launch FSM feeding uart_tx one frame at a time.
//   clk, rst (sync, active-high) plain ports; bus (slave) carries the write strobe,
//   uart_tx busy/done, overflow clear, and the tx_start/tx_data/level/empty/full/overflow outputs.
module uart_tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_ACT, WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  overflow_q, overflow_d;
    logic                  empty, full, pop, push;

    assign empty = level_q == '0;
    assign full  = level_q == FULL_LVL;
    // A launch only happens from IDLE, which re-checks tx_busy so a frame left
    // running across a reset is never overrun.
    assign pop   = state_q == IDLE && !empty && !bus.tx_busy;
    // A full queue still accepts a byte when the head leaves on the same edge.
    assign push  = bus.wr_valid && (!full || pop);

    always_comb begin
        rd_ptr_d   = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        level_d    = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        tx_start_d = pop;
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
        overflow_d = (bus.wr_valid && !push) ? 1'b1 : bus.clr_overflow ? 1'b0 : overflow_q;
        state_d    = state_q;
        case (state_q)
            IDLE:      state_d = pop ? WAIT_ACT : IDLE;
            // A frame may finish before busy is ever seen; done wins.
            WAIT_ACT:  state_d = bus.tx_done ? IDLE : bus.tx_busy ? WAIT_DONE : WAIT_ACT;
            WAIT_DONE: state_d = bus.tx_done ? IDLE : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.level    = level_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized scenario bench with a queue-based reference model and a uart_tx stub.
module tb_uart_tx_buffer;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int LW    = DL + 1;
    localparam int VW    = 12 + LW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_buffer_if #(.DEPTH_LOG2(DL)) bus ();
    uart_tx_buffer #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: queue contents, frame-in-flight flag, expected outputs
    logic [7:0] mq[$];
    logic       outst = 1'b0;
    logic       e_start = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic       e_ovf = 1'b0;

    // uart_tx stub and observations
    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    int         frame_len = 5;
    logic [7:0] sent[$];
    int         peak = 0;

    function automatic logic [VW-1:0] exp_vec();
        return {e_start, e_data, LW'(mq.size()), mq.size() == 0, mq.size() == DEPTH, e_ovf};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.tx_start, bus.tx_data, bus.level, bus.empty, bus.full, bus.overflow};
    endfunction

    task automatic step(input logic r, input logic wv, input logic [7:0] wd, input logic clr);
        logic pop, push;
        rst              = r;
        bus.wr_valid     = wv;
        bus.wr_data      = wd;
        bus.clr_overflow = clr;
        bus.tx_busy      = force_busy || busy_cnt > 1;
        bus.tx_done      = busy_cnt == 1;
        if (r) begin
            mq.delete();
            outst   = 1'b0;
            e_ovf   = 1'b0;
            e_start = 1'b0;
            e_data  = 8'h00;
        end else begin
            pop  = !outst && mq.size() > 0 && !bus.tx_busy;
            push = wv && (mq.size() < DEPTH || pop);
            if (wv && !push) e_ovf = 1'b1;
            else if (clr) e_ovf = 1'b0;
            if (outst && bus.tx_done) outst = 1'b0;
            e_start = pop;
            if (pop) begin
                e_data = mq.pop_front();
                outst  = 1'b1;
            end
            if (push) mq.push_back(wd);
        end
        @(posedge clk);
        #1;
        if (busy_cnt > 0) busy_cnt--;
        if (bus.tx_start) begin
            sent.push_back(bus.tx_data);
            busy_cnt = frame_len;
        end
        if (int'(bus.level) > peak) peak = int'(bus.level);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (bus.level !== '0)      begin n_bad++; $display("FAIL reset_level act=%0d exp=0", bus.level); end
        n_cmp++; if (bus.empty !== 1'b1)    begin n_bad++; $display("FAIL reset_empty act=%b exp=1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0)     begin n_bad++; $display("FAIL reset_full act=%b exp=0", bus.full); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow act=%b exp=0", bus.overflow); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start act=%b exp=0", bus.tx_start); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data act=%h exp=00", bus.tx_data); end
    endtask

    task automatic test_single();
        sent.delete();
        frame_len = 5;
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        n_cmp++; if (bus.level !== LW'(1) || bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL single_write level=%0d start=%b exp level=1 start=0", bus.level, bus.tx_start); end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_launch start=%b data=%h exp start=1 data=a5", bus.tx_start, bus.tx_data); end
        n_cmp++; if (bus.level !== '0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL single_level level=%0d empty=%b exp 0/1", bus.level, bus.empty); end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL single_cyc%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
        end
        n_cmp++; if (sent.size() != 1 || bus.tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_pulses count=%0d data=%h exp 1/a5", sent.size(), bus.tx_data); end
    endtask

    task automatic test_burst();
        logic ok;
        sent.delete();
        peak = 0;
        frame_len = 60;
        for (int b = 1; b <= 5; b++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b0, i == 0, 8'(b), 1'b0);
                n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL burst_b%0d_cyc%0d act=%h exp=%h", b, i, act_vec(), exp_vec()); end
            end
        end
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL burst_drain%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
        end
        n_cmp++; if (peak != 4) begin n_bad++; $display("FAIL burst_peak act=%0d exp=4", peak); end
        ok = sent.size() == 5;
        for (int i = 0; i < 5 && ok; i++) ok = sent[i] == 8'(i + 1);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_order count=%0d exp 5 bytes 01..05", sent.size()); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL burst_overflow act=%b exp=0", bus.overflow); end
    endtask

    task automatic test_overflow();
        logic ok;
        sent.delete();
        frame_len = 5;
        force_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 8'h10 + 8'(k), 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL ovf_wr%0d act=%h exp=%h", k, act_vec(), exp_vec()); end
            if (k == 3) begin
                n_cmp++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_full4 full=%b ovf=%b exp 1/0", bus.full, bus.overflow); end
            end
        end
        n_cmp++; if (bus.overflow !== 1'b1 || bus.level !== LW'(4)) begin n_bad++; $display("FAIL ovf_set ovf=%b level=%0d exp 1/4", bus.overflow, bus.level); end
        step(1'b0, 1'b1, 8'h99, 1'b1);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_priority act=%b exp=1", bus.overflow); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear act=%b exp=0", bus.overflow); end
        force_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL ovf_drain%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
        end
        ok = sent.size() == 4;
        for (int i = 0; i < 4 && ok; i++) ok = sent[i] == 8'h10 + 8'(i);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_order count=%0d exp 4 bytes 10..13", sent.size()); end
    endtask

    task automatic test_full_push_pop();
        logic ok;
        sent.delete();
        force_busy = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'h20 + 8'(k), 1'b0);
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL fpp_full act=%b exp=1", bus.full); end
        force_busy = 1'b0;
        step(1'b0, 1'b1, 8'h24, 1'b0);
        n_cmp++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h20) begin n_bad++; $display("FAIL fpp_launch start=%b data=%h exp 1/20", bus.tx_start, bus.tx_data); end
        n_cmp++; if (bus.level !== LW'(4) || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_level level=%0d ovf=%b exp 4/0", bus.level, bus.overflow); end
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL fpp_drain%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
        end
        ok = sent.size() == 5;
        for (int i = 0; i < 5 && ok; i++) ok = sent[i] == 8'h20 + 8'(i);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fpp_order count=%0d exp 5 bytes 20..24", sent.size()); end
    endtask

    task automatic test_reset_mid();
        frame_len = 40;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'h31 + 8'(k), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (bus.level !== LW'(3) || busy_cnt < 2) begin n_bad++; $display("FAIL rmid_queued level=%0d exp=3 busy_cnt=%0d", bus.level, busy_cnt); end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        sent.delete();
        n_cmp++; if (bus.level !== '0 || bus.empty !== 1'b1 || bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL rmid_flush level=%0d empty=%b start=%b exp 0/1/0", bus.level, bus.empty, bus.tx_start); end
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 80; i++) begin
            logic was_busy;
            was_busy = busy_cnt > 1;
            step(1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL rmid_cyc%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
            if (bus.tx_start && was_busy) begin n_cmp++; n_bad++; $display("FAIL rmid_launch_while_busy cyc=%0d start=1 exp=0", i); end
        end
        n_cmp++; if (sent.size() != 1 || (sent.size() == 1 && sent[0] !== 8'h3C)) begin n_bad++; $display("FAIL rmid_sent count=%0d exp one byte 3c", sent.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0] wl[$];
        logic       ok;
        logic       wv;
        logic [7:0] d;
        sent.delete();
        for (int c = 0; c < 700; c++) begin
            frame_len = $urandom_range(1, 6);
            wv = wl.size() < 3 * DEPTH && mq.size() < DEPTH && $urandom_range(0, 2) == 0;
            d  = 8'($urandom);
            if (wv) wl.push_back(d);
            step(1'b0, wv, d, 1'b0);
            n_cmp++; if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL wrap_cyc%0d act=%h exp=%h", c, act_vec(), exp_vec()); end
        end
        ok = wl.size() == 3 * DEPTH && sent.size() == wl.size();
        for (int i = 0; i < wl.size() && ok; i++) ok = sent[i] == wl[i];
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_scoreboard sent=%0d written=%0d exp %0d in order", sent.size(), wl.size(), 3 * DEPTH); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_overflow act=%b exp=0", bus.overflow); end
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        bus.clr_overflow = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
